// File: rtl/conv_enc.sv
// Rate-1/2, K=3 convolutional encoder with a one-deep valid/ready symbol register.
// Optional trellis termination (2 zero tail bits) is built when CONV_ENC_TAIL_EN is defined.
module conv_enc #(
  parameter int       FRAME_LEN = 8,
  parameter bit [2:0] G0        = 3'b111,
  parameter bit [2:0] G1        = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [1:0] enc_state,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
`ifdef CONV_ENC_TAIL_EN
    TAIL = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    sym_nxt;
  logic          vld_nxt;
  logic          done_nxt;
  logic          load_ok;
`ifdef CONV_ENC_TAIL_EN
  logic          tail_idx, tail_nxt;
`endif

  // Symbol is {c0,c1}; generator bit2 taps the current input, bits1:0 tap the shift register.
  function automatic logic [1:0] encode(input logic b, input logic [1:0] s);
    return {^(G0 & {b, s}), ^(G1 & {b, s})};
  endfunction

  assign load_ok   = !sym_valid || sym_ready;
  assign busy      = (state != IDLE);
  assign enc_state = st;

  always_comb begin
    state_nxt = state;
    st_nxt    = st;
    cnt_nxt   = cnt;
    sym_nxt   = sym_out;
    vld_nxt   = sym_valid;
    done_nxt  = 1'b0;
    din_ready = 1'b0;
`ifdef CONV_ENC_TAIL_EN
    tail_nxt  = tail_idx;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          st_nxt    = 2'b00;
          cnt_nxt   = '0;
`ifdef CONV_ENC_TAIL_EN
          tail_nxt  = 1'b0;
`endif
          state_nxt = DATA;
        end
      end
      DATA: begin
        din_ready = load_ok;
        if (din_valid && load_ok) begin
          sym_nxt = encode(din, st);
          vld_nxt = 1'b1;
          st_nxt  = {din, st[1]};
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST_IDX) begin
`ifdef CONV_ENC_TAIL_EN
            state_nxt = TAIL;
`else
            state_nxt = DONE;
`endif
          end
        end else if (load_ok) begin
          vld_nxt = 1'b0;
        end
      end
`ifdef CONV_ENC_TAIL_EN
      TAIL: begin
        if (load_ok) begin
          sym_nxt  = encode(1'b0, st);
          vld_nxt  = 1'b1;
          st_nxt   = {1'b0, st[1]};
          tail_nxt = 1'b1;
          if (tail_idx) state_nxt = DONE;
        end
      end
`endif
      DONE: begin
        // Hold the final symbol until it has been taken, then signal completion.
        if (load_ok) begin
          vld_nxt   = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      st         <= 2'b00;
      cnt        <= '0;
      sym_out    <= 2'b00;
      sym_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      tail_idx   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      st         <= st_nxt;
      cnt        <= cnt_nxt;
      sym_out    <= sym_nxt;
      sym_valid  <= vld_nxt;
      frame_done <= done_nxt;
`ifdef CONV_ENC_TAIL_EN
      tail_idx   <= tail_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_conv_enc.sv
// Directed bench for conv_enc: hand-computed symbol streams, backpressure, mid-frame start and reset.
module tb_conv_enc;

  localparam int FL = 8;
`ifdef CONV_ENC_TAIL_EN
  localparam int NSYM = FL + 2;
`else
  localparam int NSYM = FL;
`endif

  logic       clk = 1'b0;
  logic       rst, start, din, din_valid, sym_ready;
  logic       din_ready, sym_valid, busy, frame_done;
  logic [1:0] sym_out, enc_state;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_sym [0:FL+1];
  logic [1:0] exp_end;

  conv_enc #(.FRAME_LEN(FL)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sym_out    (sym_out),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .enc_state  (enc_state),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_nominal();
    exp_sym = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b11, 2'b00};
`ifdef CONV_ENC_TAIL_EN
    exp_end = 2'b00;
`else
    exp_end = 2'b01;
`endif
  endtask

  task automatic set_ones();
    exp_sym = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
`ifdef CONV_ENC_TAIL_EN
    exp_end = 2'b00;
`else
    exp_end = 2'b11;
`endif
  endtask

  task automatic set_zeros();
    exp_sym = '{default: 2'b00};
    exp_end = 2'b00;
  endtask

  // Called just before a rising edge; returns at posedge+#1.
  task automatic run_frame(input string name, input logic [7:0] bits,
                           input int stall_len, input bit start_mid);
    int  i = 0, nsym = 0, cyc = 0, stall_rem = 0, done_n = 0;
    int  last_cyc = -10, done_cyc = -10, acc0 = -1, j;
    bit  stalled = 0, finished = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!finished && cyc < 200) begin
      j = (i < FL) ? (FL - 1 - i) : 0;
      din_valid = (i < FL);
      din = (i < FL) ? bits[j] : 1'b0;
      if (stall_len > 0 && !stalled && nsym == 2 && sym_valid) begin
        stalled = 1;
        stall_rem = stall_len;
      end
      sym_ready = (stall_rem == 0);
      if (stall_rem > 0) stall_rem--;
      start = start_mid && (i == 3);
      @(negedge clk);
      if (!sym_ready) begin
        check({name, ":stall_sym"}, sym_out, exp_sym[2]);
        check({name, ":stall_vld"}, sym_valid, 1);
        check({name, ":stall_din_rdy"}, din_ready, 0);
      end
      if (acc0 >= 0 && cyc == acc0 + 1) begin
        check({name, ":lat_vld"}, sym_valid, 1);
        check({name, ":lat_sym"}, sym_out, exp_sym[0]);
      end
      if (din_valid && din_ready) begin
        if (i == 0) acc0 = cyc;
        i++;
      end
      if (sym_valid && sym_ready) begin
        if (nsym < NSYM) check($sformatf("%s:sym%0d", name, nsym), sym_out, exp_sym[nsym]);
        nsym++;
        last_cyc = cyc;
      end
      if (frame_done) begin
        done_n++;
        if (done_n == 1) begin
          done_cyc = cyc;
          check({name, ":end_state"}, enc_state, exp_end);
        end
      end
      if (done_n > 0 && cyc == done_cyc + 3) finished = 1;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    din_valid = 1'b0;
    sym_ready = 1'b1;
    check({name, ":finished"}, finished, 1);
    check({name, ":done_count"}, done_n, 1);
    check({name, ":sym_count"}, nsym, NSYM);
    check({name, ":done_timing"}, done_cyc, last_cyc + 1);
    check({name, ":idle_busy"}, busy, 0);
  endtask

  initial begin
    int acc = 0, guard = 0;
    rst = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0; sym_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst:sym_out", sym_out, 0);
    check("rst:sym_valid", sym_valid, 0);
    check("rst:din_ready", din_ready, 0);
    check("rst:busy", busy, 0);
    check("rst:frame_done", frame_done, 0);
    check("rst:enc_state", enc_state, 0);

    set_nominal(); run_frame("nominal", 8'b10110010, 0, 0);
    set_ones();    run_frame("ones",    8'b11111111, 0, 0);
    set_zeros();   run_frame("zeros",   8'b00000000, 0, 0);
    set_nominal(); run_frame("bp",      8'b10110010, 3, 0);
    set_nominal(); run_frame("restart", 8'b10110010, 0, 1);

    // Abort a frame after four accepted ones, then re-encode cleanly.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; din = 1'b1; din_valid = 1'b1; sym_ready = 1'b1;
    while (acc < 4 && guard < 50) begin
      @(negedge clk);
      if (din_valid && din_ready) acc++;
      @(posedge clk); #1;
      guard++;
    end
    check("abort:accepted", acc, 4);
    check("abort:pre_state", enc_state, 2'b11);
    rst = 1'b1; din_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort:sym_valid", sym_valid, 0);
    check("abort:busy", busy, 0);
    check("abort:enc_state", enc_state, 0);
    check("abort:din_ready", din_ready, 0);
    set_nominal(); run_frame("after_rst", 8'b10110010, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_enc.md
Name: conv_enc

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder's trellis / survivor-path memory.
- Accepts a frame of FRAME_LEN information bits over a valid/ready handshake and emits one 2-bit code symbol per bit.
- Optionally appends K-1 = 2 zero tail bits so the trellis terminates in state 00. That matches the decoder's traceback start node 00.

Parameters:
- FRAME_LEN, 8, information bits per frame (= decoder trellis depth); legal range 1..255.
- G0, 3'b111, generator polynomial for symbol bit 1; bit2 = current input, bit1 = st[1], bit0 = st[0].
- G1, 3'b101, generator polynomial for symbol bit 0; same bit mapping as G0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame start request; honoured only in IDLE.
- din  in  1  information bit.
- din_valid  in  1  din qualifier.
- din_ready  out  1  encoder accepts din this cycle.
- sym_out  out  2  code symbol {c0,c1}; c0 = parity(G0 & {b,st}), c1 = parity(G1 & {b,st}).
- sym_valid  out  1  sym_out holds a valid symbol.
- sym_ready  in  1  downstream consumes sym_out.
- enc_state  out  2  encoder shift register st = {b[n-1], b[n-2]}.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  single-cycle pulse after the last symbol of a frame is consumed.

Behaviour:
- Reset, with rst sampled high on a clk edge:
  - FSM goes to IDLE; st = 00; bit counter = 0.
  - sym_out = 00, sym_valid = 0, din_ready = 0, busy = 0, frame_done = 0.
  - Reset mid-frame aborts the frame immediately. Any pending symbol is dropped (sym_valid = 0 the next cycle).
- Output register is one symbol deep.
  - load_ok = !sym_valid || sym_ready.
  - While sym_valid && !sym_ready, sym_out and sym_valid must hold stable.
- FSM states: IDLE, DATA, TAIL, DONE.
- IDLE:
  - din_ready = 0.
  - On start = 1: st <= 00, counter <= 0, go to DATA.
- DATA:
  - din_ready = load_ok.
  - Accept on din_valid && din_ready: sym_out <= {c0,c1}, sym_valid <= 1, st <= {din, st[1]}, counter++.
  - If load_ok and no accept, sym_valid <= 0.
  - On acceptance of bit FRAME_LEN-1, go to TAIL, or to DONE when tail generation is compiled out.
- TAIL:
  - din_ready = 0; internal input bit is 0.
  - Emit exactly 2 symbols, each loaded only when load_ok, using the same update rules as DATA.
  - After the second tail symbol is loaded, go to DONE.
- DONE:
  - Wait until load_ok, i.e. the last symbol is consumed or was already consumed.
  - In that cycle: sym_valid <= 0, frame_done <= 1 for one cycle, go to IDLE.
- Latency: a symbol appears (sym_valid = 1) the cycle after its bit is accepted.
- Full throughput: with sym_ready held high, one symbol per cycle.
- start while busy is ignored; it is not queued.
- start and din_valid in the same IDLE cycle: din is not accepted, because din_ready = 0 in IDLE.
- Symbols per frame: FRAME_LEN+2 with tail, FRAME_LEN without tail.
- Counter width is $clog2(FRAME_LEN+1). The counter never wraps inside a frame.

Optional Feature:
- Macro: CONV_ENC_TAIL_EN.
- Defined: the TAIL state exists and 2 zero tail bits are appended, so enc_state = 00 at frame_done.
- Undefined: TAIL is removed and DATA goes directly to DONE. The frame ends in whatever state the data leaves, and only FRAME_LEN symbols are emitted.

Test Plan:
- Nominal frame, tail on, sym_ready = 1, start, din = 1,0,1,1,0,0,1,0 on consecutive cycles:
  - sym_out = 11,10,00,01,01,11,11,10, then tail symbols 11,00.
  - enc_state = 00; frame_done pulses one cycle after the final symbol.
- Same frame with CONV_ENC_TAIL_EN undefined:
  - exactly 8 symbols 11,10,00,01,01,11,11,10.
  - enc_state = 01 at frame_done.
- Backpressure: sym_ready = 0 for 3 cycles after the 3rd symbol:
  - sym_out holds 00 with sym_valid = 1 throughout.
  - din_ready = 0 throughout.
  - Stream resumes with no loss or duplication.
- All-zero frame of 8 bits: all 10 symbols = 00; enc_state stays 00.
- start asserted during DATA of a frame: ignored; the current frame completes with a single frame_done.
- rst asserted after the 4th accepted bit:
  - next cycle: sym_valid = 0, busy = 0, enc_state = 00.
  - a subsequent start re-encodes from state 00 correctly.
